// File: rtl/rng_pkg.sv
// Shared types and tap constants for the LFSR range RNG.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } rng_fsm_t;

  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and all-zero lock-up recovery.
module lfsr_core #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_val,
  output logic [WIDTH-1:0] o_state,
  output logic             o_lockup
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_core: SEED must be non-zero");
  end

  logic [WIDTH-1:0] r_state;
  logic             r_lockup;
  logic [WIDTH-1:0] w_state_nxt;
  logic             w_lockup_nxt;
  logic             w_feedback;

  assign w_feedback = ^(r_state & TAPS);

  // Seed load beats recovery, recovery beats stepping.
  always_comb begin
    w_state_nxt  = r_state;
    w_lockup_nxt = 1'b0;
    if (i_seed_load) begin
      if (i_seed_val == '0) begin
        w_state_nxt  = SEED;
        w_lockup_nxt = 1'b1;
      end else begin
        w_state_nxt = i_seed_val;
      end
    end else if (r_state == '0) begin
      w_state_nxt  = SEED;
      w_lockup_nxt = 1'b1;
    end else if (i_advance) begin
      w_state_nxt = {r_state[WIDTH-2:0], w_feedback};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lockup <= w_lockup_nxt;
    end
  end

  assign o_state  = r_state;
  assign o_lockup = r_lockup;

endmodule

// File: rtl/lfsr_rng_range.sv
// LFSR random source with a valid/ready port returning unbiased values in [0, limit-1].
module lfsr_rng_range
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'hA5,
  parameter int unsigned      OUT_W     = 4,
  parameter int unsigned      MAX_TRIES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W:0]   limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam int unsigned LIM_W = OUT_W + 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES) + 1;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rng_range: WIDTH must be 3..32");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng_range: OUT_W must be 1..WIDTH");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng_range: MAX_TRIES must be >= 1");
  end

  rng_fsm_t         r_fsm,       w_fsm_nxt;
  logic [LIM_W-1:0] r_lim,       w_lim_nxt;
  logic [TRY_W-1:0] r_tries,     w_tries_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [OUT_W-1:0] r_rsp_data,  w_rsp_data_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;

  logic [WIDTH-1:0] w_state;
  logic             w_lockup;
  logic             w_advance;
  logic [OUT_W-1:0] w_cand;

  // The LFSR keeps stepping while a draw is in flight even with en low.
  assign w_advance = en || (r_fsm == DRAW);
  assign w_cand    = w_state[OUT_W-1:0];

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_advance   (w_advance),
    .i_seed_load (seed_load),
    .i_seed_val  (seed_val),
    .o_state     (w_state),
    .o_lockup    (w_lockup)
  );

  // Next-state and response logic.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_lim_nxt       = r_lim;
    w_tries_nxt     = r_tries;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    unique case (r_fsm)
      IDLE: begin
        if (req_valid) begin
          w_lim_nxt   = limit;
          w_tries_nxt = '0;
          if (limit == '0) begin
            w_fsm_nxt       = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_fsm_nxt = DRAW;
          end
        end
      end
      DRAW: begin
        if ({1'b0, w_cand} < r_lim) begin
          w_fsm_nxt       = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_cand;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
          w_fsm_nxt       = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_tries_nxt = TRY_W'(r_tries + 1'b1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_fsm_nxt       = IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_fsm_nxt       = IDLE;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
    w_req_ready_nxt = (w_fsm_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_lim       <= '0;
      r_tries     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_lim       <= w_lim_nxt;
      r_tries     <= w_tries_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign state     = w_state;
  assign lockup    = w_lockup;

endmodule

// File: tb/tb_lfsr_rng_range.sv
// Self-checking bench: transaction-level rejection-sampling model over the LFSR sequence.
module tb_lfsr_rng_range;

  localparam int MAX_TRIES = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, seed_load, req_valid, rsp_ready;
  logic [7:0] seed_val;
  logic [4:0] limit;
  logic       req_ready, rsp_valid, rsp_err, lockup;
  logic [3:0] rsp_data;
  logic [7:0] state;

  logic       en4;
  logic       zero1 = 1'b0;
  logic [3:0] zero4 = 4'h0;
  logic [2:0] zero3 = 3'h0;
  logic       req_ready4, rsp_valid4, rsp_err4, lockup4;
  logic [1:0] rsp_data4;
  logic [3:0] state4;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_state;
  int         hist [16];
  bit         seen [256];

  always #5 clk = ~clk;

  lfsr_rng_range dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .req_valid(req_valid), .req_ready(req_ready), .limit(limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .state(state), .lockup(lockup)
  );

  lfsr_rng_range #(
    .WIDTH(4), .TAPS(rng_pkg::TAPS_4), .SEED(4'hA), .OUT_W(2), .MAX_TRIES(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .seed_load(zero1), .seed_val(zero4),
    .req_valid(zero1), .req_ready(req_ready4), .limit(zero3),
    .rsp_valid(rsp_valid4), .rsp_ready(zero1), .rsp_data(rsp_data4),
    .rsp_err(rsp_err4), .state(state4), .lockup(lockup4)
  );

  function automatic logic [7:0] step8(input logic [7:0] s);
    int ones = 0;
    for (int b = 0; b < 8; b++) if (b == 3 || b == 4 || b == 5 || b == 7) ones += int'(s[b]);
    return {s[6:0], 1'(ones % 2)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request: the expected answer is the first candidate below lim in the state sequence.
  task automatic run_req(input int lim, input int hold);
    logic [7:0] s;
    logic [3:0] exp_d;
    logic       exp_e;
    int         k, cyc;
    bit         got, done;
    s = m_state; exp_e = 1'b1; exp_d = 4'h0; k = MAX_TRIES - 1; done = 0;
    for (int i = 0; i < MAX_TRIES; i++) begin
      if (!done) begin
        if (int'(s[3:0]) < lim) begin
          exp_e = 1'b0; exp_d = s[3:0]; k = i; done = 1;
        end
        s = step8(s);
      end
    end
    req_valid = 1'b1; limit = 5'(lim); cyc = 0; got = 0;
    while (!got && cyc < MAX_TRIES + 8) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      got = rsp_valid;
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(k + 2));
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    check("state_after_draw", 32'(state), 32'(s));
    if (!exp_e) check("data_below_limit", 32'(int'(rsp_data) < lim), 32'd1);
    if (got && !rsp_err) hist[rsp_data]++;
    m_state = s;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp_d));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_state", 32'(state), 32'(m_state));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int cyc, distinct, n, v;
    bit got;
    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_val = 8'h00;
    req_valid = 1'b0; rsp_ready = 1'b0; limit = 5'd0; en4 = 1'b0;
    foreach (hist[i]) hist[i] = 0;
    foreach (seen[i]) seen[i] = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'hA5);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_lockup", 32'(lockup), 32'd0);
    check("rst_state4", 32'(state4), 32'hA);
    rst_n = 1'b1; en4 = 1'b1;
    m_state = 8'hA5;

    // Legacy 4-bit sequence
    check("legacy_0", 32'(state4), 32'hA);
    @(negedge clk); check("legacy_1", 32'(state4), 32'h5);
    @(negedge clk); check("legacy_2", 32'(state4), 32'hB);
    @(negedge clk); check("legacy_3", 32'(state4), 32'h7);
    @(negedge clk); check("legacy_4", 32'(state4), 32'hF);
    en4 = 1'b0;
    check("idle_hold_state", 32'(state), 32'hA5);

    // Full period with default taps
    en = 1'b1;
    seen[state] = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      m_state = step8(m_state);
      check("freerun_state", 32'(state), 32'(m_state));
      if (lockup !== 1'b0) check("freerun_lockup", 32'(lockup), 32'd0);
      if (i < 254) seen[state] = 1'b1;
    end
    en = 1'b0;
    distinct = 0;
    foreach (seen[i]) distinct += int'(seen[i]);
    check("period_distinct", 32'(distinct), 32'd255);
    check("period_no_zero", 32'(seen[0]), 32'd0);
    check("period_wrap", 32'(state), 32'hA5);

    // Zero seed load recovers to SEED with a single lockup pulse
    seed_load = 1'b1; seed_val = 8'h00;
    @(negedge clk);
    seed_load = 1'b0;
    check("zero_seed_state", 32'(state), 32'hA5);
    check("zero_seed_lockup", 32'(lockup), 32'd1);
    @(negedge clk);
    check("lockup_pulse_end", 32'(lockup), 32'd0);
    seed_load = 1'b1; seed_val = 8'h3C;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed_load_state", 32'(state), 32'h3C);
    check("seed_load_no_lockup", 32'(lockup), 32'd0);
    m_state = 8'h3C;

    // limit=16 accepts the first candidate; response held under backpressure
    run_req(16, 10);

    // limit=0 is an immediate error response
    req_valid = 1'b1; limit = 5'd0; cyc = 0; got = 0;
    while (!got && cyc < 2) begin
      @(negedge clk); req_valid = 1'b0; cyc++; got = rsp_valid;
    end
    check("lim0_seen", 32'(got), 32'd1);
    check("lim0_err", 32'(rsp_err), 32'd1);
    check("lim0_data", 32'(rsp_data), 32'd0);
    check("lim0_state", 32'(state), 32'(m_state));
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    check("lim0_hs", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a draw
    req_valid = 1'b1; limit = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_draw_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_state", 32'(state), 32'hA5);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; m_state = 8'hA5;
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_state", 32'(state), 32'hA5);

    // 1000 requests with limit=5
    foreach (hist[i]) hist[i] = 0;
    for (int r = 0; r < 1000; r++) run_req(5, 0);
    for (int i = 0; i < 5; i++) check("hist_min", 32'(hist[i] >= 150), 32'd1);
    for (int i = 5; i < 16; i++) check("hist_out_of_range", 32'(hist[i]), 32'd0);

    // Random mix of free-run, seed loads and requests
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = int'($urandom_range(1, 20));
          en = 1'b1;
          repeat (n) begin @(negedge clk); m_state = step8(m_state); end
          en = 1'b0;
          check("rnd_freerun", 32'(state), 32'(m_state));
        end
        1: begin
          v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
          seed_load = 1'b1; seed_val = 8'(v);
          @(negedge clk);
          seed_load = 1'b0;
          m_state = (v == 0) ? 8'hA5 : 8'(v);
          check("rnd_seed_state", 32'(state), 32'(m_state));
          check("rnd_seed_lockup", 32'(lockup), 32'(v == 0));
        end
        default: run_req(int'($urandom_range(1, 16)), int'($urandom_range(0, 3)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
